// File: rtl/axil_ctrl_pkg.sv
// Register map constants, response codes and W-channel payload for the accelerator control slave.
package axil_ctrl_pkg;

  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_STATUS   = 1;
  localparam int unsigned REG_CFG_BASE = 2;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_LOAD_BIT  = 1;
  localparam int unsigned CTRL_LAYER_LSB = 2;

  localparam int unsigned STATUS_DONE_BIT = 0;
  localparam int unsigned STATUS_BUSY_BIT = 1;
  localparam int unsigned STATUS_CNT_LSB  = 16;
  localparam int unsigned STATUS_CNT_W    = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } axil_w_t;

  // Byte-strobe merge of a write beat into an existing 32-bit word.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry holding slot for an AXI-Lite address or data beat.
module axil_hold_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  input  logic         i_allow,
  input  logic         i_consume,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         valid_q, valid_d;
  logic         ready_q, ready_d;
  logic [W-1:0] data_q, data_d;

  // Capture on handshake, free on consume; ready only when empty and the owner allows.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_consume) valid_d = 1'b0;
    if (i_valid && ready_q) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end
    ready_d = !valid_d && i_allow;
  end

  // Slot state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite control/status register file for the DMA load path: CTRL, STATUS, CFG[].
module axil_ctrl_regs
  import axil_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned LAYER_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        s_axi_awaddr,
  input  logic [2:0]               s_axi_awprot,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDR_W-1:0]        s_axi_araddr,
  input  logic [2:0]               s_axi_arprot,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic                     o_start,
  output logic                     o_load_state,
  output logic [LAYER_W-1:0]       o_current_layer,
  output logic [(NUM_REGS-2)*32-1:0] o_cfg,
  input  logic                     i_last
);

  localparam int unsigned IDX_W   = ADDR_W - 2;
  localparam int unsigned NUM_CFG = NUM_REGS - 2;

  logic                  aw_valid, w_valid, commit_c, wr_ok_c, allow_c;
  logic [ADDR_W-1:0]     aw_addr;
  axil_w_t               w_in_c, w_held;
  logic [IDX_W-1:0]      wr_idx_c, rd_idx_c;
  logic [31:0]           ctrl_word_c, ctrl_merged_c, rd_word_c;

  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  start_q, start_d;
  logic                  load_q, load_d;
  logic [LAYER_W-1:0]    layer_q, layer_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [STATUS_CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CFG*32-1:0] cfg_q, cfg_d;

  assign w_in_c = '{data: s_axi_wdata, strb: s_axi_wstrb};

  axil_hold_reg #(.W(ADDR_W)) u_aw_hold (
    .clk(clk), .rst(rst),
    .i_valid(s_axi_awvalid), .i_data(s_axi_awaddr), .o_ready(s_axi_awready),
    .i_allow(allow_c), .i_consume(commit_c),
    .o_valid(aw_valid), .o_data(aw_addr)
  );

  axil_hold_reg #(.W($bits(axil_w_t))) u_w_hold (
    .clk(clk), .rst(rst),
    .i_valid(s_axi_wvalid), .i_data(w_in_c), .o_ready(s_axi_wready),
    .i_allow(allow_c), .i_consume(commit_c),
    .o_valid(w_valid), .o_data(w_held)
  );

  assign commit_c      = aw_valid && w_valid && !bvalid_q;
  assign wr_idx_c      = aw_addr[ADDR_W-1:2];
  assign rd_idx_c      = s_axi_araddr[ADDR_W-1:2];
  assign wr_ok_c       = 32'(wr_idx_c) < NUM_REGS;
  assign ctrl_word_c   = 32'({layer_q, load_q, 1'b0});
  assign ctrl_merged_c = strb_merge(ctrl_word_c, w_held.data, w_held.strb);

  // Write response: raise on commit, drop on B handshake; new beats blocked while pending.
  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
    if (commit_c) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok_c ? RESP_OKAY : RESP_SLVERR;
    end
    allow_c = !bvalid_d;
  end

  // Register file update: CTRL/CFG byte writes, start pulse, sticky done/busy/count.
  always_comb begin
    load_d  = load_q;
    layer_d = layer_q;
    cfg_d   = cfg_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    if (commit_c && wr_ok_c) begin
      if (32'(wr_idx_c) == REG_CTRL) begin
        load_d  = ctrl_merged_c[CTRL_LOAD_BIT];
        layer_d = ctrl_merged_c[CTRL_LAYER_LSB +: LAYER_W];
        start_d = w_held.strb[0] && w_held.data[CTRL_START_BIT] && !busy_q;
      end
      if (32'(wr_idx_c) == REG_STATUS && w_held.strb[0] && w_held.data[STATUS_DONE_BIT]) begin
        done_d = 1'b0;
      end
      for (int unsigned k = 0; k < NUM_CFG; k++) begin
        if (32'(wr_idx_c) == REG_CFG_BASE + k) begin
          cfg_d[k*32 +: 32] = strb_merge(cfg_q[k*32 +: 32], w_held.data, w_held.strb);
        end
      end
    end
    if (i_last) begin
      done_d = 1'b1;
      busy_d = 1'b0;
      cnt_d  = cnt_q + STATUS_CNT_W'(1);
    end
    if (start_d) busy_d = 1'b1;
  end

  // Read mux over the current (pre-commit) register contents.
  always_comb begin
    rd_word_c = '0;
    if (32'(rd_idx_c) == REG_CTRL) begin
      rd_word_c = ctrl_word_c;
    end else if (32'(rd_idx_c) == REG_STATUS) begin
      rd_word_c[STATUS_DONE_BIT] = done_q;
      rd_word_c[STATUS_BUSY_BIT] = busy_q;
      rd_word_c[STATUS_CNT_LSB +: STATUS_CNT_W] = cnt_q;
    end
    for (int unsigned k = 0; k < NUM_CFG; k++) begin
      if (32'(rd_idx_c) == REG_CFG_BASE + k) rd_word_c = cfg_q[k*32 +: 32];
    end
  end

  // Read channel: capture on AR handshake, hold until R handshake.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
    if (s_axi_arvalid && arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word_c;
      rresp_d  = (32'(rd_idx_c) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
    end
    arready_d = !rvalid_d;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      start_q   <= 1'b0;
      load_q    <= 1'b0;
      layer_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      cfg_q     <= '0;
    end else begin
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      start_q   <= start_d;
      load_q    <= load_d;
      layer_q   <= layer_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      cfg_q     <= cfg_d;
    end
  end

  assign s_axi_bvalid    = bvalid_q;
  assign s_axi_bresp     = bresp_q;
  assign s_axi_arready   = arready_q;
  assign s_axi_rvalid    = rvalid_q;
  assign s_axi_rdata     = rdata_q;
  assign s_axi_rresp     = rresp_q;
  assign o_start         = start_q;
  assign o_load_state    = load_q;
  assign o_current_layer = layer_q;
  assign o_cfg           = cfg_q;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_c;
  assign unused_c = ^{s_axi_awprot, s_axi_arprot, aw_addr[1:0], s_axi_araddr[1:0], ctrl_merged_c};

endmodule

// File: doc/axil_ctrl_regs.md
# axil_ctrl_regs

Parametrised AXI4-Lite control/status slave driving the accelerator's DMA load path. Replaces the fixed single-register write-only control port with a NUM_REGS register file, a full read channel, byte strobes, independent AW/W acceptance, a self-clearing start pulse, and a sticky done/busy status fed by the stream-last signal. Sits between the PS AXI-Lite master and the load/layer sequencer.

## Interface
Parameters:
- NUM_REGS, 4, total 32-bit registers; minimum 3
- ADDR_W, 4, AXI address width; 2^ADDR_W ≥ NUM_REGS*4
- LAYER_W, 2, width of current-layer field; ≤ 29

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_axi_awaddr/awprot/awvalid  in  ADDR_W/3/1; s_axi_awready  out  1
- s_axi_wdata/wstrb/wvalid  in  32/4/1; s_axi_wready  out  1
- s_axi_bresp/bvalid  out  2/1; s_axi_bready  in  1
- s_axi_araddr/arprot/arvalid  in  ADDR_W/3/1; s_axi_arready  out  1
- s_axi_rdata/rresp/rvalid  out  32/2/1; s_axi_rready  in  1
- o_start  out  1  one-cycle start pulse
- o_load_state  out  1  CTRL.load_state
- o_current_layer  out  LAYER_W  CTRL.layer
- o_cfg  out  (NUM_REGS-2)*32  CFG registers, reg 2 in LSBs
- i_last  in  1  end-of-transfer pulse (stream tlast handshake)

## Operation
- Register map (word index = addr[ADDR_W-1:2]; addr[1:0] ignored):
  - 0 CTRL: bit0 start (write-1 pulses o_start, reads 0), bit1 load_state, bits[LAYER_W+1:2] layer; other bits read 0
  - 1 STATUS: bit0 done (sticky, set by i_last, W1C), bit1 busy (RO), bits[31:16] done_count (RO, increments on every i_last, wraps at 16 bits)
  - 2..NUM_REGS-1 CFG: plain RW
- wstrb honoured per byte on CTRL and CFG; STATUS W1C uses wstrb[0]. Start requires wstrb[0].
- Start: accepted only when busy=0 → o_start=1 one cycle, busy←1. Ignored while busy (load_state/layer still update).
- i_last: done←1, busy←0, done_count+1. Simultaneous i_last and done W1C: set wins. Simultaneous i_last and accepted start: busy←1.
- Index ≥ NUM_REGS: write discarded, read returns 0; both respond SLVERR (2'b10). Otherwise OKAY (2'b00).
- awprot/arprot ignored.

## Timing
- Reset values: all readies 0, bvalid/rvalid 0, bresp/rresp 0, rdata 0, o_start 0, all registers 0, busy/done 0, done_count 0.
- awready/wready/arready go 1 in first cycle after rst deasserts.
- AW and W accepted independently, in either order or same cycle; each holds its beat and drops its ready the cycle after its handshake.
- Commit: first edge at which both AW and W are held → register update and bvalid=1 visible next cycle; o_start high in that same cycle.
- bvalid held until bready; awready/wready re-assert the cycle after the B handshake. No second write accepted while bvalid=1.
- Read: AR handshake at edge N → rvalid, rdata, rresp valid after N; held stable until rready; arready low while rvalid=1, re-asserts the cycle after the R handshake. rdata sampled at the AR handshake edge.
- Read and write channels are independent; a read in the commit cycle returns pre-write data.
- rst mid-transaction: all held beats and pending responses dropped, outputs return to reset values the next cycle.

## Structure
- Package axil_ctrl_pkg: register index constants (CTRL=0, STATUS=1, CFG_BASE=2), CTRL/STATUS bit positions, RESP_OKAY/RESP_SLVERR.
- Sub-module axil_hold_reg: one-entry valid/data holding slot with ready output, instantiated for AW (ADDR_W) and W (36 bits: data+strb).

## Test plan
- Reset, then write CTRL=0x0000_000F (wstrb=0xF) → o_start pulses 1 cycle, o_load_state=1, o_current_layer=3, busy=1, bresp=OKAY.
- W beat 3 cycles before AW, bready held low 4 cycles → no commit until AW arrives; bvalid stays 1; awready/wready stay 0 until B handshake.
- Write CFG reg 2=0xAABBCCDD, then wstrb=0x2 with 0x0000_1100 → read returns 0xAABB11DD, o_cfg[31:0] matches.
- Pulse i_last twice → STATUS reads done=1, busy=0, done_count=2; W1C with i_last in same cycle → done stays 1.
- Second start while busy → no o_start pulse; i_last then start → pulse.
- Read/write index NUM_REGS → SLVERR, rdata=0, no register changes.
